// File: rtl/vec_reg_file.sv
// Vector register file: NREGS registers of N x BITS elements plus a length field,
// two registered read ports, one parallel write port and a byte-serial load/store engine.
module vec_reg_file #(
  parameter int unsigned N     = 64,
  parameter int unsigned BITS  = 8,
  parameter int unsigned NREGS = 8,
  parameter int unsigned RAW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RAW-1:0]           rd_a_sel,
  input  logic [RAW-1:0]           rd_b_sel,
  output logic [N-1:0][BITS-1:0]   rd_a_data,
  output logic [N-1:0][BITS-1:0]   rd_b_data,
  output logic [BITS-1:0]          rd_a_len,
  output logic [BITS-1:0]          rd_b_len,
  input  logic                     wr_en,
  input  logic [RAW-1:0]           wr_sel,
  input  logic [N-1:0][BITS-1:0]   wr_data,
  input  logic [BITS-1:0]          wr_len,
  input  logic                     ld_start,
  input  logic [RAW-1:0]           ld_sel,
  input  logic [BITS-1:0]          ld_len,
  input  logic [BITS-1:0]          in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     st_start,
  input  logic [RAW-1:0]           st_sel,
  output logic [BITS-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FIN} state_t;

  logic [BITS-1:0] mem   [NREGS][N];
  logic [BITS-1:0] len_q [NREGS];

  state_t         state_q, state_d;
  logic [RAW-1:0] sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           elem_we_c;
  logic           len_we_c;
  logic           last_c;

  // Lengths above N saturate at N rather than wrapping into the counter width.
  function automatic logic [CW-1:0] clamp_len(input logic [BITS-1:0] l);
    if (32'(l) > 32'(N)) return CW'(N);
    else                 return CW'(l);
  endfunction

  assign last_c = (CW'(idx_q + CW'(1)) == cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    elem_we_c = 1'b0;
    len_we_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          sel_d = ld_sel;
          cnt_d = clamp_len(ld_len);
          idx_d = '0;
          if (cnt_d == '0) begin
            len_we_c = 1'b1;
            state_d  = FIN;
          end else begin
            state_d  = LOAD;
          end
        end else if (st_start) begin
          sel_d   = st_sel;
          cnt_d   = CW'(len_q[st_sel]);
          idx_d   = '0;
          state_d = (cnt_d == '0) ? FIN : STORE;
        end
      end
      LOAD: begin
        if (in_valid) begin
          elem_we_c = 1'b1;
          idx_d     = CW'(idx_q + CW'(1));
          if (last_c) begin
            len_we_c = 1'b1;
            state_d  = FIN;
          end
        end
      end
      STORE: begin
        if (out_ready) begin
          idx_d = CW'(idx_q + CW'(1));
          if (last_c) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write priority: load element, then parallel write, then the load's final length.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        len_q[r] <= '0;
        for (int e = 0; e < N; e++) mem[r][e] <= '0;
      end
    end else begin
      if (elem_we_c) mem[sel_q][idx_q[IW-1:0]] <= in_data;
      if (wr_en) begin
        for (int e = 0; e < N; e++) mem[wr_sel][e] <= wr_data[e];
        len_q[wr_sel] <= BITS'(clamp_len(wr_len));
      end
      if (len_we_c) len_q[sel_d] <= BITS'(cnt_d);
    end
  end

  // Read-old registered read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
      rd_a_len  <= '0;
      rd_b_len  <= '0;
    end else begin
      for (int e = 0; e < N; e++) begin
        rd_a_data[e] <= mem[rd_a_sel][e];
        rd_b_data[e] <= mem[rd_b_sel][e];
      end
      rd_a_len <= len_q[rd_a_sel];
      rd_b_len <= len_q[rd_b_sel];
    end
  end

  // Handshake and status flags decode the registered state directly.
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == STORE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign out_data  = (state_q == STORE) ? mem[sel_q][idx_q[IW-1:0]] : '0;

endmodule

// File: tb/tb_vec_reg_file.sv
// Directed self-checking bench for vec_reg_file.
module tb_vec_reg_file;

  localparam int unsigned N     = 64;
  localparam int unsigned BITS  = 8;
  localparam int unsigned NREGS = 8;
  localparam int unsigned RAW   = 3;

  logic                   clk;
  logic                   rst;
  logic [RAW-1:0]         rd_a_sel, rd_b_sel;
  logic [N-1:0][BITS-1:0] rd_a_data, rd_b_data;
  logic [BITS-1:0]        rd_a_len, rd_b_len;
  logic                   wr_en;
  logic [RAW-1:0]         wr_sel;
  logic [N-1:0][BITS-1:0] wr_data;
  logic [BITS-1:0]        wr_len;
  logic                   ld_start;
  logic [RAW-1:0]         ld_sel;
  logic [BITS-1:0]        ld_len;
  logic [BITS-1:0]        in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   st_start;
  logic [RAW-1:0]         st_sel;
  logic [BITS-1:0]        out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic                   done;

  int n_tests = 0;
  int n_fail  = 0;

  vec_reg_file #(.N(N), .BITS(BITS), .NREGS(NREGS), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .rd_a_len(rd_a_len), .rd_b_len(rd_b_len),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_len(wr_len),
    .ld_start(ld_start), .ld_sel(ld_sel), .ld_len(ld_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .st_start(st_start), .st_sel(st_sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    int beats;
    int dones;
    int fin;
    logic [3:0] pat;

    rst = 1'b1; rd_a_sel = '0; rd_b_sel = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; wr_len = '0;
    ld_start = 1'b0; ld_sel = '0; ld_len = '0; in_data = '0; in_valid = 1'b0;
    st_start = 1'b0; st_sel = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state across every register on both ports.
    for (int s = 0; s < NREGS; s++) begin
      rd_a_sel = RAW'(s);
      rd_b_sel = RAW'(NREGS - 1 - s);
      tick();
      check("rst_a_data", 32'(|rd_a_data), 32'd0);
      check("rst_b_data", 32'(|rd_b_data), 32'd0);
      check("rst_a_len", 32'(rd_a_len), 32'd0);
      check("rst_b_len", 32'(rd_b_len), 32'd0);
      check("rst_flags", {28'd0, in_ready, out_valid, busy, done}, 32'd0);
    end
    check("rst_out_data", 32'(out_data), 32'd0);

    // Zero-stall load of 5 elements into reg 3.
    ld_start = 1'b1; ld_sel = 3'd3; ld_len = 8'd5;
    tick();
    ld_start = 1'b0;
    check("ld_in_ready", 32'(in_ready), 32'd1);
    check("ld_busy", 32'(busy), 32'd1);
    in_valid = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h11 + i);
      if (done) dones++;
      tick();
    end
    in_valid = 1'b0;
    check("ld_done", 32'(done), 32'd1);
    check("ld_early_done", 32'(dones), 32'd0);
    check("ld_ready_drop", 32'(in_ready), 32'd0);
    tick();
    check("ld_done_pulse", 32'(done), 32'd0);
    check("ld_idle", 32'(busy), 32'd0);
    rd_a_sel = 3'd3;
    tick();
    for (int e = 0; e < 5; e++) check("ld_elem", 32'(rd_a_data[e]), 32'(8'h11 + e));
    check("ld_rest_zero", 32'(|rd_a_data[N-1:5]), 32'd0);
    check("ld_len", 32'(rd_a_len), 32'd5);

    // Store reg 3 with out_ready pattern 1,0,0,1.
    pat = 4'b1001;
    st_start = 1'b1; st_sel = 3'd3;
    tick();
    st_start = 1'b0;
    check("st_valid", 32'(out_valid), 32'd1);
    beats = 0; dones = 0; fin = 0;
    for (int c = 0; c < 40 && fin == 0; c++) begin
      out_ready = pat[c % 4];
      if (out_valid) check("st_data", 32'(out_data), 32'(8'h11 + beats));
      if (out_valid && out_ready) beats++;
      tick();
      if (done) begin dones++; fin = 1; end
    end
    out_ready = 1'b0;
    check("st_finished", 32'(fin), 32'd1);
    check("st_beats", 32'(beats), 32'd5);
    check("st_valid_drop", 32'(out_valid), 32'd0);
    tick();
    check("st_done_pulse", 32'(done), 32'd0);

    // Oversized load clamps to N.
    ld_start = 1'b1; ld_sel = 3'd5; ld_len = 8'd200;
    tick();
    ld_start = 1'b0;
    in_valid = 1'b1; hs = 0; fin = 0;
    for (int c = 0; c < 80 && fin == 0; c++) begin
      in_data = 8'(c + 1);
      if (in_ready) hs++;
      tick();
      if (done) fin = 1;
    end
    in_valid = 1'b0;
    check("big_finished", 32'(fin), 32'd1);
    check("big_handshakes", 32'(hs), 32'd64);
    tick();
    rd_a_sel = 3'd5;
    tick();
    check("big_len", 32'(rd_a_len), 32'd64);
    check("big_last", 32'(rd_a_data[63]), 32'd64);

    // Store from a length-0 register.
    st_start = 1'b1; st_sel = 3'd6;
    tick();
    st_start = 1'b0;
    check("st0_valid", 32'(out_valid), 32'd0);
    check("st0_done", 32'(done), 32'd1);
    tick();
    check("st0_idle", {30'd0, out_valid, busy}, 32'd0);

    // Parallel write with same-edge read: read-old, then new data with clamped length.
    for (int e = 0; e < N; e++) wr_data[e] = 8'(8'hA0 + e);
    wr_en = 1'b1; wr_sel = 3'd3; wr_len = 8'd100; rd_a_sel = 3'd3;
    tick();
    wr_en = 1'b0;
    check("wr_old_elem", 32'(rd_a_data[0]), 32'h11);
    check("wr_old_len", 32'(rd_a_len), 32'd5);
    tick();
    check("wr_new_elem0", 32'(rd_a_data[0]), 32'hA0);
    check("wr_new_elem63", 32'(rd_a_data[63]), 32'hDF);
    check("wr_new_len", 32'(rd_a_len), 32'd64);

    // Simultaneous starts: the load wins.
    ld_start = 1'b1; ld_sel = 3'd1; ld_len = 8'd2;
    st_start = 1'b1; st_sel = 3'd3;
    tick();
    ld_start = 1'b0; st_start = 1'b0;
    check("pri_in_ready", 32'(in_ready), 32'd1);
    check("pri_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    check("pri_done", 32'(done), 32'd1);
    rd_b_sel = 3'd1;
    tick();
    tick();
    check("pri_len", 32'(rd_b_len), 32'd2);
    check("pri_elem1", 32'(rd_b_data[1]), 32'h66);

    // Reset mid-load after 2 of 4 elements.
    ld_start = 1'b1; ld_sel = 3'd2; ld_len = 8'd4;
    tick();
    ld_start = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_data = 8'h88;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_flags", {28'd0, in_ready, out_valid, busy, done}, 32'd0);
    dones = 0;
    rd_a_sel = 3'd2; rd_b_sel = 3'd3;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) dones++;
    end
    check("rstm_no_done", 32'(dones), 32'd0);
    check("rstm_a_data", 32'(|rd_a_data), 32'd0);
    check("rstm_b_data", 32'(|rd_b_data), 32'd0);
    check("rstm_b_len", 32'(rd_b_len), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
